// File: rtl/block_transfer_sequencer_pkg.sv
// Shared definitions for the block transfer sequencer: state encoding, the
// default byte step and the lowest-set-bit helper used to walk the register list.
package block_transfer_sequencer_pkg;

  localparam int BTS_STEP_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MEM  = 3'd1,
    ST_WB   = 3'd2,
    ST_BASE = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic [3:0] lowestSetIndex(input logic [15:0] list);
    logic [3:0] idx;
    idx = 4'd0;
    // Scanning downwards leaves the lowest set index as the final value.
    for (int i = 15; i >= 0; i--) begin
      if (list[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/block_transfer_sequencer_popcount16.sv
// Combinational population count of a 16-bit register list.
module popcount16 (
  input  logic [15:0] i_bits,
  output logic [4:0]  o_count
);

  always_comb begin
    o_count = 5'd0;
    for (int i = 0; i < 16; i++) begin
      o_count = o_count + {4'd0, i_bits[i]};
    end
  end

endmodule

// File: rtl/block_transfer_sequencer.sv
// ARM-style LDM/STM sequencer: walks a 16-bit register list, issuing one memory
// access per register, writing loads back to the register file and updating the base.
module block_transfer_sequencer
  import block_transfer_sequencer_pkg::*;
#(
  parameter int DW   = 32,
  parameter int STEP = BTS_STEP_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_load,
  input  logic [15:0]   i_regList,
  input  logic [3:0]    i_baseReg,
  input  logic [DW-1:0] i_baseAddr,
  input  logic          i_up,
  input  logic          i_preIndex,
  input  logic          i_writeBack,
  output logic          o_memReq,
  output logic          o_memWrite,
  output logic [DW-1:0] o_memAddr,
  output logic [DW-1:0] o_memWrData,
  input  logic          i_memDone,
  input  logic [DW-1:0] i_memRdData,
  output logic [3:0]    o_rfAddrOut,
  input  logic [DW-1:0] i_rfDataOut,
  output logic [3:0]    o_rfAddrIn,
  output logic [DW-1:0] o_rfDataIn,
  output logic          o_rfEnable,
  output logic          o_busy,
  output logic          o_done
);

  state_t        r_state;
  logic [15:0]   r_list;
  logic          r_load;
  logic          r_baseWrite;
  logic [3:0]    r_baseReg;
  logic [DW-1:0] r_newBase;
  logic [DW-1:0] r_addr;
  logic          r_memReq;
  logic          r_memWrite;
  logic [3:0]    r_rfAddrOut;
  logic [3:0]    r_rfAddrIn;
  logic [DW-1:0] r_rfDataIn;
  logic          r_rfEnable;
  logic          r_busy;
  logic          r_done;

  logic [4:0]    w_cnt;
  logic [DW-1:0] w_span;
  logic [DW-1:0] w_firstAddr;
  logic [DW-1:0] w_nextAddr;
  logic [15:0]   w_remaining;
  logic [3:0]    w_cur;
  logic [3:0]    w_nextReg;
  logic          w_advance;

  popcount16 u_popcount (
    .i_bits  (i_regList),
    .o_count (w_cnt)
  );

  assign w_span      = DW'(STEP) * DW'(w_cnt);
  assign w_nextAddr  = r_addr + DW'(STEP);
  assign w_remaining = r_list & (r_list - 16'd1);
  assign w_cur       = lowestSetIndex(r_list);
  assign w_nextReg   = lowestSetIndex(w_remaining);
  assign w_advance   = ((r_state == ST_MEM) && i_memDone && !r_load) || (r_state == ST_WB);

  // Decrementing modes still walk upwards, so the lowest address is computed up front.
  always_comb begin
    case ({i_preIndex, i_up})
      2'b01:   w_firstAddr = i_baseAddr;
      2'b11:   w_firstAddr = i_baseAddr + DW'(STEP);
      2'b00:   w_firstAddr = i_baseAddr - w_span + DW'(STEP);
      default: w_firstAddr = i_baseAddr - w_span;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_list      <= '0;
      r_load      <= 1'b0;
      r_baseWrite <= 1'b0;
      r_baseReg   <= '0;
      r_newBase   <= '0;
      r_addr      <= '0;
      r_memReq    <= 1'b0;
      r_memWrite  <= 1'b0;
      r_rfAddrOut <= '0;
      r_rfAddrIn  <= '0;
      r_rfDataIn  <= '0;
      r_rfEnable  <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rfEnable <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_list      <= i_regList;
            r_load      <= i_load;
            r_baseReg   <= i_baseReg;
            r_newBase   <= i_up ? (i_baseAddr + w_span) : (i_baseAddr - w_span);
            r_baseWrite <= i_writeBack && !(i_load && i_regList[i_baseReg]);
            r_addr      <= w_firstAddr;
            r_rfAddrOut <= lowestSetIndex(i_regList);
            r_busy      <= 1'b1;
            if (i_regList != 16'd0) begin
              r_state    <= ST_MEM;
              r_memReq   <= 1'b1;
              r_memWrite <= ~i_load;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_MEM: begin
          if (i_memDone && r_load) begin
            r_memReq   <= 1'b0;
            r_rfEnable <= 1'b0;
            r_rfAddrIn <= w_cur;
            r_rfDataIn <= i_memRdData;
            r_state    <= ST_WB;
          end
        end
        ST_WB: ;
        ST_BASE: r_state <= ST_DONE;
        // Done is presented in the first IDLE cycle so Busy covers the DONE state itself.
        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_advance) begin
        r_list <= w_remaining;
        r_addr <= w_nextAddr;
        if (w_remaining != 16'd0) begin
          r_state     <= ST_MEM;
          r_memReq    <= 1'b1;
          r_rfAddrOut <= w_nextReg;
        end else begin
          r_memReq   <= 1'b0;
          r_memWrite <= 1'b0;
          if (r_baseWrite) begin
            r_state    <= ST_BASE;
            r_rfEnable <= 1'b0;
            r_rfAddrIn <= r_baseReg;
            r_rfDataIn <= r_newBase;
          end else begin
            r_state <= ST_DONE;
          end
        end
      end
    end
  end

  assign o_memReq    = r_memReq;
  assign o_memWrite  = r_memWrite;
  assign o_memAddr   = r_addr;
  assign o_memWrData = (r_memReq && r_memWrite) ? i_rfDataOut : '0;
  assign o_rfAddrOut = r_rfAddrOut;
  assign o_rfAddrIn  = r_rfAddrIn;
  assign o_rfDataIn  = r_rfDataIn;
  assign o_rfEnable  = r_rfEnable;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: doc/block_transfer_sequencer.md
BLOCK_TRANSFER_SEQUENCER -- requirements
Module: block_transfer_sequencer

Interface
REQ-001 Parameter DW, default 32, data and address width.
REQ-002 Parameter STEP, default 4, byte increment per transferred word.
REQ-003 Clk  in  1  single clock; all state updates on rising edge.
REQ-004 Clr  in  1  asynchronous, active-low reset.
REQ-005 Start  in  1  request a block transfer; sampled only in IDLE.
REQ-006 Load  in  1  1 = LDM (memory to registers), 0 = STM (registers to memory).
REQ-007 RegList  in  16  register list; bit n selects register n.
REQ-008 BaseReg  in  4  base register index.
REQ-009 BaseAddr  in  DW  base register value.
REQ-010 Up, PreIndex, WriteBack  in  1 each  ARM U, P and W bits.
REQ-011 MemReq  out  1  memory request, held until MemDone.
REQ-012 MemWrite  out  1  1 = write to memory; valid with MemReq.
REQ-013 MemAddr, MemWrData  out  DW each  address and store data; valid with MemReq.
REQ-014 MemDone  in  1  memory completion strobe, one cycle.
REQ-015 MemRdData  in  DW  load data; valid in the MemDone cycle.
REQ-016 RfAddrOut  out  4  register-file read address (STM source).
REQ-017 RfDataOut  in  DW  register-file read data (combinational).
REQ-018 RfAddrIn, RfDataIn  out  4, DW  register-file write address and data.
REQ-019 RfEnable  out  1  register-file write enable, active-low; low for exactly one cycle per write.
REQ-020 Busy, Done  out  1 each  Busy is high from the cycle after Start accept until Done; Done is a one-cycle pulse.

Function
REQ-021 States SHALL be IDLE, MEM, WB, BASE and DONE.
REQ-022 IDLE with Start=1: latch all inputs, cnt = popcount(RegList), and first address; go to MEM (go to DONE if RegList == 0).
REQ-023 First address: P=0,U=1 -> Base; P=1,U=1 -> Base+STEP; P=0,U=0 -> Base-STEP*cnt+STEP; P=1,U=0 -> Base-STEP*cnt; all arithmetic modulo 2^DW.
REQ-024 Registers SHALL be transferred in ascending index order at ascending addresses, lowest set bit first.
REQ-025 MEM: MemReq=1, MemAddr = current address, MemWrite = ~Load, RfAddrOut = current register, MemWrData = RfDataOut; all held stable until MemDone.
REQ-026 MEM with MemDone: if STM, clear the bit and advance the address by STEP; if LDM, capture MemRdData and go to WB.
REQ-027 WB: RfEnable=0, RfAddrIn = current register, RfDataIn = captured data for one cycle; then clear the bit and advance the address.
REQ-028 When no bits remain: go to BASE if WriteBack=1 and not (Load=1 and RegList[BaseReg]=1); otherwise go to DONE.
REQ-029 BASE: write Base+STEP*cnt (U=1) or Base-STEP*cnt (U=0) to BaseReg with RfEnable=0 for one cycle.
REQ-030 DONE: Done=1 and Busy=0 for one cycle; return to IDLE; Start is accepted again in the next cycle.
REQ-031 Start while not in IDLE SHALL be ignored; input changes after the accept cycle SHALL have no effect.
REQ-032 MemReq SHALL be low in WB, BASE, DONE and IDLE; MemDone outside MEM SHALL be ignored.

Reset
REQ-033 Clr low SHALL immediately force IDLE, abort any transfer, and clear all latched state.
REQ-034 Reset output values: MemReq=0, MemWrite=0, Busy=0, Done=0, all buses 0, RfEnable=1.

Structure
REQ-035 A shared package SHALL hold the state encoding and the STEP default.
REQ-036 One sub-module, popcount16, SHALL compute cnt combinationally.

Verification
REQ-037 STM, P=0,U=1,W=1, list 0x000B, base R13 = 0x100, zero-wait MemDone -> writes to 0x100/0x104/0x108 from R0/R1/R3; R13 = 0x10C; Done pulses once.
REQ-038 LDM, P=1,U=0,W=0, list 0x8001, base 0x200 -> reads 0x1F8 -> R0, then 0x1FC -> R15; each RfEnable low pulse lasts one cycle; no base write.
REQ-039 LDM with W=1 and base R2 in list 0x0004 -> R2 = loaded value; no BASE cycle.
REQ-040 RegList=0 -> no MemReq; Done pulses two cycles after Start.
REQ-041 MemDone delayed 3 cycles and Start pulsed while Busy -> MemReq and MemAddr held stable; the extra Start is ignored.
REQ-042 Clr asserted during MEM of a 4-register LDM -> MemReq=0 and RfEnable=1 immediately; no further writes; the next Start runs normally.
